// File: rtl/jam_pkg.sv
// Shared types and helpers for the exhaustive job-assignment solver.
package jam_pkg;

  localparam int unsigned MAX_N     = 8;
  localparam int unsigned MAX_IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    NEXT  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } jam_state_e;

  // Largest permutation container: MAX_N fields of MAX_IDX_W bits, field w = job of worker w.
  typedef logic [MAX_N-1:0][MAX_IDX_W-1:0] jam_perm_t;

  // Accumulated cost width: N entries of cost_w bits never overflow this.
  function automatic int unsigned jam_sum_w(input int unsigned cost_w, input int unsigned n);
    return cost_w + $clog2(n);
  endfunction

endpackage

// File: rtl/jam_perm_gen.sv
// Combinational lexicographic next-permutation step; is_last flags the fully descending permutation.
module jam_perm_gen #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0][IDX_W-1:0] perm,
  output logic [N-1:0][IDX_W-1:0] next_perm,
  output logic                    is_last
);

  int unsigned             piv;
  int unsigned             succ;
  logic                    found;
  logic [IDX_W-1:0]        piv_val;
  logic [IDX_W-1:0]        succ_val;
  logic [N-1:0][IDX_W-1:0] swapped;

  // All selects use constant loop indices so the logic flattens into compare/mux trees.
  always_comb begin
    found     = 1'b0;
    piv       = 0;
    succ      = 0;
    piv_val   = '0;
    succ_val  = '0;
    swapped   = perm;
    next_perm = perm;

    for (int unsigned i = 0; i + 1 < N; i++) begin
      if (perm[i] < perm[i+1]) begin
        found = 1'b1;
        piv   = i;
      end
    end

    for (int unsigned i = 0; i < N; i++) begin
      if (i == piv) piv_val = perm[i];
    end

    // Suffix is descending, so the last larger element is the smallest one above the pivot.
    for (int unsigned i = 0; i < N; i++) begin
      if ((i > piv) && (perm[i] > piv_val)) succ = i;
    end

    for (int unsigned i = 0; i < N; i++) begin
      if (i == succ) succ_val = perm[i];
    end

    for (int unsigned i = 0; i < N; i++) begin
      if (i == piv) swapped[i] = succ_val;
      else if (i == succ) swapped[i] = piv_val;
    end

    next_perm = swapped;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned m = 0; m < N; m++) begin
        if ((i > piv) && (m == N + piv - i)) next_perm[i] = swapped[m];
      end
    end

    is_last = ~found;
  end

endmodule

// File: rtl/jam_solver.sv
// Exhaustive N-worker/N-job assignment solver: walks all N! permutations in lexicographic
// order against an external cost ROM and keeps the best total, its tie count and first winner.
module jam_solver
  import jam_pkg::*;
#(
  parameter  int unsigned N        = 8,
  parameter  int unsigned COST_W   = 7,
  parameter  int unsigned COST_LAT = 1,
  parameter  int unsigned CNT_W    = 16,
  localparam int unsigned IDX_W    = $clog2(N),
  localparam int unsigned SUM_W    = jam_sum_w(COST_W, N)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic               MODE_MAX,
  output logic               BUSY,
  output logic [IDX_W-1:0]   W,
  output logic [IDX_W-1:0]   J,
  input  logic [COST_W-1:0]  Cost,
  output logic [CNT_W-1:0]   MatchCount,
  output logic [SUM_W-1:0]   BestCost,
  output logic [N*IDX_W-1:0] BestPerm,
  output logic               Valid
);

  typedef logic [N-1:0][IDX_W-1:0] perm_t;

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N - 1);

  function automatic perm_t ident_perm();
    perm_t p;
    for (int unsigned i = 0; i < N; i++) p[i] = IDX_W'(i);
    return p;
  endfunction

  localparam perm_t IDENT = ident_perm();

  jam_state_e       state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  perm_t            perm_q, perm_d;
  logic [IDX_W-1:0] w_d, j_d;
  logic             busy_d, valid_d;
  logic             mode_q, mode_d;
  logic             tok_v, tok_first, tok_last;
  logic             start_run;
  logic             pipe_empty;

  perm_t            next_perm;
  logic             is_last;

  logic [COST_LAT:0]        tv_v, tv_first, tv_last;
  perm_t [COST_LAT:0]       tv_perm;
  logic [SUM_W-1:0]         sum_q;
  logic                     cmp_pend;
  perm_t                    cmp_perm;
  logic                     best_empty;
  logic                     better;

  jam_perm_gen #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_perm_gen (
    .perm      (perm_q),
    .next_perm (next_perm),
    .is_last   (is_last)
  );

  assign pipe_empty = ~(|tv_v) & ~cmp_pend;

  // State and FSM-owned output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      k_q     <= '0;
      perm_q  <= IDENT;
      W       <= '0;
      J       <= '0;
      BUSY    <= 1'b0;
      Valid   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      perm_q  <= perm_d;
      W       <= w_d;
      J       <= j_d;
      BUSY    <= busy_d;
      Valid   <= valid_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    perm_d    = perm_q;
    w_d       = W;
    j_d       = J;
    busy_d    = BUSY;
    valid_d   = Valid;
    mode_d    = mode_q;
    tok_v     = 1'b0;
    tok_first = 1'b0;
    tok_last  = 1'b0;
    start_run = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (START) begin
          start_run = 1'b1;
          state_d   = CALC;
          k_d       = '0;
          perm_d    = IDENT;
          busy_d    = 1'b1;
          valid_d   = 1'b0;
          mode_d    = MODE_MAX;
        end
      end
      CALC: begin
        w_d       = k_q;
        j_d       = perm_q[k_q];
        tok_v     = 1'b1;
        tok_first = (k_q == '0);
        tok_last  = (k_q == K_LAST);
        if (k_q == K_LAST) state_d = NEXT;
        else k_d = k_q + IDX_W'(1);
      end
      NEXT: begin
        k_d = '0;
        if (is_last) begin
          state_d = DRAIN;
        end else begin
          perm_d  = next_perm;
          state_d = CALC;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          state_d = DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign better = mode_q ? (sum_q > BestCost) : (sum_q < BestCost);

  // Token pipeline aligned with ROM latency, accumulator and best-result compare.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tv_v       <= '0;
      tv_first   <= '0;
      tv_last    <= '0;
      tv_perm    <= '0;
      sum_q      <= '0;
      cmp_pend   <= 1'b0;
      cmp_perm   <= IDENT;
      best_empty <= 1'b1;
      BestCost   <= '0;
      BestPerm   <= IDENT;
      MatchCount <= '0;
    end else begin
      tv_v     <= {tv_v[COST_LAT-1:0], tok_v};
      tv_first <= {tv_first[COST_LAT-1:0], tok_first};
      tv_last  <= {tv_last[COST_LAT-1:0], tok_last};
      tv_perm  <= {tv_perm[COST_LAT-1:0], perm_q};

      if (tv_v[COST_LAT]) begin
        sum_q <= (tv_first[COST_LAT] ? '0 : sum_q) + SUM_W'(Cost);
      end
      cmp_pend <= tv_v[COST_LAT] & tv_last[COST_LAT];
      if (tv_v[COST_LAT] && tv_last[COST_LAT]) cmp_perm <= tv_perm[COST_LAT];

      if (start_run) begin
        MatchCount <= '0;
        best_empty <= 1'b1;
      end else if (cmp_pend) begin
        // Ties only count; BestPerm stays at the lexicographically first winner.
        if (best_empty || better) begin
          BestCost   <= sum_q;
          BestPerm   <= cmp_perm;
          MatchCount <= CNT_W'(1);
          best_empty <= 1'b0;
        end else if ((sum_q == BestCost) && (MatchCount != {CNT_W{1'b1}})) begin
          MatchCount <= MatchCount + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_jam_solver.sv
// Bench for jam_solver: directed vector table, START/reset corner sequences and random cost
// matrices checked against an enumerating reference model.
module tb_jam_solver;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N=3, COST_LAT=1 instance
  logic        start3, mode3, busy3, valid3;
  logic [1:0]  w3, j3;
  logic [6:0]  cost3_d;
  logic [15:0] mc3;
  logic [8:0]  bc3;
  logic [5:0]  bp3;
  logic [6:0]  cost3 [3][3];

  jam_solver #(.N(3), .COST_W(7), .COST_LAT(1), .CNT_W(16)) u3 (
    .CLK(clk), .RST_N(rst_n), .START(start3), .MODE_MAX(mode3), .BUSY(busy3),
    .W(w3), .J(j3), .Cost(cost3_d), .MatchCount(mc3), .BestCost(bc3),
    .BestPerm(bp3), .Valid(valid3)
  );

  always @(posedge clk) cost3_d <= cost3[w3][j3];

  // N=6, COST_LAT=2 instance
  logic        start6, mode6, busy6, valid6;
  logic [2:0]  w6, j6;
  logic [6:0]  cost6_p, cost6_d;
  logic [15:0] mc6;
  logic [9:0]  bc6;
  logic [17:0] bp6;
  logic [6:0]  cost6 [6][6];

  jam_solver #(.N(6), .COST_W(7), .COST_LAT(2), .CNT_W(16)) u6 (
    .CLK(clk), .RST_N(rst_n), .START(start6), .MODE_MAX(mode6), .BUSY(busy6),
    .W(w6), .J(j6), .Cost(cost6_d), .MatchCount(mc6), .BestCost(bc6),
    .BestPerm(bp6), .Valid(valid6)
  );

  always @(posedge clk) begin
    cost6_p <= cost6[w6][j6];
    cost6_d <= cost6_p;
  end

  typedef struct packed {
    logic            mode;
    logic [0:8][6:0] c;
    logic [8:0]      best;
    logic [0:2][1:0] perm;
    logic [15:0]     cnt;
  } vec_t;

  vec_t vt [4];

  int ref_best;
  int ref_cnt;
  int ref_bp [8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Enumerate every n-digit base-n tuple in numeric order; permutations appear lexicographically.
  task automatic ref_model(input int n, input bit mode);
    int  total = 1;
    int  d [8];
    bit  used [8];
    bit  ok;
    bit  have = 0;
    int  s;
    int  r;
    for (int i = 0; i < n; i++) total *= n;
    ref_best = 0;
    ref_cnt  = 0;
    for (int t = 0; t < total; t++) begin
      r = t;
      for (int i = n - 1; i >= 0; i--) begin
        d[i] = r % n;
        r    = r / n;
      end
      ok = 1'b1;
      for (int i = 0; i < 8; i++) used[i] = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (used[d[i]]) ok = 1'b0;
        used[d[i]] = 1'b1;
      end
      if (ok) begin
        s = 0;
        for (int i = 0; i < n; i++) begin
          if (n == 3) s += int'(cost3[i][d[i]]);
          else s += int'(cost6[i][d[i]]);
        end
        if (!have || (mode ? (s > ref_best) : (s < ref_best))) begin
          have     = 1'b1;
          ref_best = s;
          ref_cnt  = 1;
          for (int i = 0; i < n; i++) ref_bp[i] = d[i];
        end else if (s == ref_best) begin
          ref_cnt++;
        end
      end
    end
  endtask

  function automatic longint pack_ref(input int n, input int iw);
    longint p = 0;
    for (int i = 0; i < n; i++) p |= longint'(ref_bp[i]) << (i * iw);
    return p;
  endfunction

  function automatic longint pack3(input logic [0:2][1:0] p);
    return longint'({p[2], p[1], p[0]});
  endfunction

  task automatic run3(input bit mode, input bit poke, output int lat);
    @(negedge clk);
    start3 = 1'b1;
    mode3  = mode;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    chk("n3_busy_at_start", longint'(busy3), 1);
    chk("n3_valid_cleared", longint'(valid3), 0);
    chk("n3_count_cleared", longint'(mc3), 0);
    lat = 0;
    while (!valid3 && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      start3 = poke && (lat == 2 || lat == 9);
      mode3  = start3 ? ~mode : mode;
    end
    start3 = 1'b0;
    mode3  = mode;
  endtask

  task automatic check3(input string tag, input int lat, input int best, input int cnt,
                        input longint perm);
    chk({tag, "_latency"}, longint'(lat), 27);
    chk({tag, "_best"}, longint'(bc3), longint'(best));
    chk({tag, "_count"}, longint'(mc3), longint'(cnt));
    chk({tag, "_perm"}, longint'(bp3), perm);
    chk({tag, "_busy"}, longint'(busy3), 0);
  endtask

  task automatic run6(input bit mode, output int lat);
    @(negedge clk);
    start6 = 1'b1;
    mode6  = mode;
    @(posedge clk);
    #1;
    start6 = 1'b0;
    chk("n6_busy_at_start", longint'(busy6), 1);
    lat = 0;
    while (!valid6 && lat < 6000) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic check6(input string tag, input int lat, input int best, input int cnt,
                        input longint perm);
    chk({tag, "_latency"}, longint'(lat), 720 * 7 + 2 + 2);
    chk({tag, "_best"}, longint'(bc6), longint'(best));
    chk({tag, "_count"}, longint'(mc6), longint'(cnt));
    chk({tag, "_perm"}, longint'(bp6), perm);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int     lat;
    bit     m;
    longint id6;
    longint rev6;

    vt[0] = '{mode: 1'b0, c: {7'd5, 7'd9, 7'd1, 7'd7, 7'd2, 7'd8, 7'd4, 7'd6, 7'd3},
              best: 9'd7, perm: {2'd2, 2'd1, 2'd0}, cnt: 16'd1};
    vt[1] = '{mode: 1'b1, c: {7'd5, 7'd9, 7'd1, 7'd7, 7'd2, 7'd8, 7'd4, 7'd6, 7'd3},
              best: 9'd21, perm: {2'd1, 2'd2, 2'd0}, cnt: 16'd1};
    vt[2] = '{mode: 1'b0, c: '0,
              best: 9'd0, perm: {2'd0, 2'd1, 2'd2}, cnt: 16'd6};
    vt[3] = '{mode: 1'b1, c: {9{7'd3}},
              best: 9'd9, perm: {2'd0, 2'd1, 2'd2}, cnt: 16'd6};

    id6  = 0;
    rev6 = 0;
    for (int i = 0; i < 6; i++) begin
      id6  |= longint'(i) << (3 * i);
      rev6 |= longint'(5 - i) << (3 * i);
    end

    rst_n  = 1'b0;
    start3 = 1'b0;
    mode3  = 1'b0;
    start6 = 1'b0;
    mode6  = 1'b0;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) cost3[i][j] = 7'd0;
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) cost6[i][j] = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_w", longint'(w3), 0);
    chk("rst_j", longint'(j3), 0);
    chk("rst_busy", longint'(busy3), 0);
    chk("rst_valid", longint'(valid3), 0);
    chk("rst_count", longint'(mc3), 0);
    chk("rst_best", longint'(bc3), 0);
    chk("rst_perm", longint'(bp3), 36);
    chk("rst_perm_n6", longint'(bp6), id6);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) cost3[i][j] = vt[k].c[i*3+j];
      run3(vt[k].mode, 1'b0, lat);
      check3($sformatf("vec%0d", k), lat, int'(vt[k].best), int'(vt[k].cnt), pack3(vt[k].perm));
    end

    // START pulses mid-run are ignored; a second START reruns to identical results
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) cost3[i][j] = vt[0].c[i*3+j];
    run3(1'b0, 1'b1, lat);
    check3("poke_run1", lat, 7, 1, 6);
    run3(1'b0, 1'b0, lat);
    check3("poke_run2", lat, 7, 1, 6);

    // Random N=3 matrices; narrow cost range in even iterations to force ties
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          cost3[i][j] = (r % 2 == 0) ? 7'($urandom_range(0, 2)) : 7'($urandom_range(0, 127));
      m = 1'($urandom_range(0, 1));
      ref_model(3, m);
      run3(m, 1'b0, lat);
      check3($sformatf("rnd3_%0d", r), lat, ref_best, ref_cnt, pack_ref(3, 2));
    end

    // N=6, COST_LAT=2: diagonal, anti-diagonal, then random
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) cost6[i][j] = (i == j) ? 7'd0 : 7'd127;
    run6(1'b0, lat);
    check6("n6_diag", lat, 0, 1, id6);
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) cost6[i][j] = (j == 5 - i) ? 7'd1 : 7'd100;
    run6(1'b0, lat);
    check6("n6_anti", lat, 6, 1, rev6);
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) cost6[i][j] = 7'($urandom_range(0, 127));
    m = 1'($urandom_range(0, 1));
    ref_model(6, m);
    run6(m, lat);
    check6("n6_rand", lat, ref_best, ref_cnt, pack_ref(6, 3));

    // Asynchronous reset in the middle of CALC
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) cost3[i][j] = vt[0].c[i*3+j];
    @(negedge clk);
    start3 = 1'b1;
    mode3  = 1'b0;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("pre_rst_busy", longint'(busy3), 1);
    chk("pre_rst_count", longint'(mc3), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_w", longint'(w3), 0);
    chk("mid_rst_j", longint'(j3), 0);
    chk("mid_rst_busy", longint'(busy3), 0);
    chk("mid_rst_valid", longint'(valid3), 0);
    chk("mid_rst_count", longint'(mc3), 0);
    chk("mid_rst_best", longint'(bc3), 0);
    chk("mid_rst_perm", longint'(bp3), 36);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) cost3[i][j] = 7'd0;
    run3(1'b0, 1'b0, lat);
    check3("post_rst", lat, 0, 6, 36);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jam_solver.md
Name: jam_solver

Overview:
- Parametrised exhaustive job-assignment solver. N workers, N jobs; enumerates all N! assignments in lexicographic order.
- Each assignment's cost is fetched from an external cost ROM through the W/J address ports.
- Reports the best total cost in either min or max mode, the number of assignments reaching it, and the first (lexicographically smallest) assignment achieving it.
- Sits beside the cost ROM; a host starts a run with a START handshake.

Parameters:
- N, 8, number of workers/jobs (2..8).
- COST_W, 7, width of one cost entry.
- COST_LAT, 1, cycles from W/J registered output to Cost valid (1..3).
- IDX_W, $clog2(N), worker/job index width (derived).
- SUM_W, COST_W+$clog2(N), accumulated cost width (derived).
- CNT_W, 16, MatchCount width (8! = 40320 fits).

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  start request; sampled only in IDLE.
- MODE_MAX  in  1  0 = minimise, 1 = maximise; latched at START.
- BUSY  out  1  high from START acceptance until Valid rises.
- W  out  IDX_W  worker address to cost ROM.
- J  out  IDX_W  job address to cost ROM.
- Cost  in  COST_W  ROM data, COST_LAT cycles after W/J.
- MatchCount  out  CNT_W  number of assignments equal to best cost.
- BestCost  out  SUM_W  best total cost.
- BestPerm  out  N*IDX_W  first best assignment; BestPerm[w*IDX_W +: IDX_W] = job of worker w.
- Valid  out  1  results valid; held until next accepted START.

Behaviour:
- Reset values: W=0, J=0, BUSY=0, Valid=0, MatchCount=0, BestCost=0, BestPerm=identity. FSM goes to IDLE; permutation register = identity; pipeline valid bits cleared. Reset mid-run aborts immediately; no partial result is ever flagged.
- States: IDLE, CALC, NEXT, DRAIN, DONE.
- IDLE:
  - START=1 latches MODE_MAX, clears Valid and MatchCount, sets the best-empty flag, sets BUSY, and enters CALC with perm = identity.
  - START is ignored in all other states.
- CALC:
  - N cycles; cycle k registers W=k, J=perm[k].
  - A valid token tagged with (first, last-of-perm) travels COST_LAT+1 stages alongside.
  - After k=N-1, go to NEXT.
- NEXT (1 cycle): next-permutation step.
  - Pivot i = largest index with perm[i] < perm[i+1].
  - Swap perm[i] with the smallest perm[j] > perm[i], j > i.
  - Reverse perm[i+1..N-1].
  - If no pivot exists (descending permutation), go to DRAIN; otherwise go to CALC.
- Accumulate stage: on a valid token, sum <= (first ? 0 : sum) + Cost, zero-extended to SUM_W. No overflow is possible by construction.
- Compare (one cycle after the last token of a permutation):
  - If the best-empty flag is set, or sum is strictly better (less than in min mode, greater than in max mode): BestCost<=sum, BestPerm<=that perm's copy, MatchCount<=1, clear best-empty.
  - If sum equals the best: MatchCount<=MatchCount+1, saturating at all-ones.
  - Ties never update BestPerm, so BestPerm is the lexicographically first best assignment.
  - The compare of permutation p overlaps CALC of permutation p+1. A per-permutation snapshot register holds perm until its compare.
- DRAIN: wait until the pipeline is empty and the final compare has completed, then go to DONE.
- DONE: Valid=1, BUSY=0. Stay until START, then re-run as from IDLE.
- Latency: Valid rises exactly N!·(N+1)+COST_LAT+2 cycles after the START-sampling edge.
- W/J are don't-care outside CALC but stay stable (hold last value).

Decomposition:
- Package jam_pkg holds:
  - state enum jam_state_e (IDLE, CALC, NEXT, DRAIN, DONE);
  - localparam function for the SUM_W derivation;
  - typedef of the packed permutation vector parameterised via a macro-free packed array of IDX_W-wide fields.
- Sub-module jam_perm_gen: purely combinational next-permutation engine. Inputs: perm. Outputs: next_perm, is_last. It is instantiated once in jam_solver.

Test Plan:
- N=3, COST_LAT=1, MODE_MAX=0, C=[[5,9,1],[7,2,8],[4,6,3]] (row=worker) -> BestCost=7, BestPerm={w0:2,w1:1,w2:0}, MatchCount=1, Valid at edge 3!·4+3=27.
- Same matrix, MODE_MAX=1 -> BestCost=21, BestPerm={1,2,0}, MatchCount=1.
- N=3, all costs 0 -> BestCost=0, MatchCount=6, BestPerm=identity (tie keeps first).
- N=8, COST_LAT=2, C[w][j]=(w==j)?0:127 -> BestCost=0, MatchCount=1, BestPerm=identity. A second run with C[w][j]=(j==7-w)?1:100 gives BestCost=8 and BestPerm={7,6,...,0}.
- Run 1 -> START pulses during CALC are ignored -> a second START after Valid recomputes identical results, and Valid drops for the duration of the second run.
- Assert RST_N low mid-CALC -> all outputs return to reset values asynchronously. A fresh START then produces correct results with no stale MatchCount.
